// File: rtl/l1v_denetleyici_pkg.sv
// Shared constants and FSM state encoding for the L1 data cache controller.
package l1v_denetleyici_pkg;

  localparam int ADRES_BIT_VARSAYILAN    = 32;
  localparam int VERI_BIT_VARSAYILAN     = 32;
  localparam int SATIR_SAYISI_VARSAYILAN = 64;
  localparam int SATIR_BAYT_VARSAYILAN   = 16;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  typedef enum logic [2:0] {
    BOSTA     = 3'd0,
    ARA       = 3'd1,
    CEVAP     = 3'd2,
    OKU_ISTE  = 3'd3,
    OKU_BEKLE = 3'd4,
    YAZ_ISTE  = 3'd5
  } durum_t;

endpackage

// File: rtl/l1v_etiket_dizisi.sv
// Valid + tag storage for the direct-mapped L1 data cache.
// Combinational read port, single write port; only the valid bits are reset.
module l1v_etiket_dizisi #(
  parameter int SATIR_SAYISI = 64,
  parameter int IDX          = 6,
  parameter int ETIKET       = 22
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX-1:0]    oku_idx,
  output logic              oku_gecerli,
  output logic [ETIKET-1:0] oku_etiket,
  input  logic              yaz_en,
  input  logic [IDX-1:0]    yaz_idx,
  input  logic [ETIKET-1:0] yaz_etiket
);

  logic [SATIR_SAYISI-1:0] gecerli_q;
  logic [ETIKET-1:0]       etiket_q [SATIR_SAYISI];

  // Valid bits: cleared on reset, set when a line is filled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gecerli_q <= '0;
    end else if (yaz_en) begin
      gecerli_q[yaz_idx] <= 1'b1;
    end
  end

  // Tag storage, meaningful only where the matching valid bit is set
  always_ff @(posedge clk_i) begin
    if (yaz_en) begin
      etiket_q[yaz_idx] <= yaz_etiket;
    end
  end

  assign oku_gecerli = gecerli_q[oku_idx];
  assign oku_etiket  = etiket_q[oku_idx];

endmodule

// File: rtl/l1v_denetleyici.sv
// L1 data cache controller: direct-mapped, write-through, write-no-allocate.
// Serves word loads/stores from the memory stage and fetches lines on a load miss.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// BOSTA     | idle, accepts a core request; stray line fills are swallowed
// ARA       | one-cycle tag lookup; store hits merge into the line here
// CEVAP     | load data presented to the core until accepted
// OKU_ISTE  | line read request held until next level accepts
// OKU_BEKLE | waiting for the line fill; fill updates arrays and response
// YAZ_ISTE  | write-through word write held until next level accepts
module l1v_denetleyici
  import l1v_denetleyici_pkg::*;
#(
  parameter int SATIR_SAYISI = SATIR_SAYISI_VARSAYILAN,
  parameter int SATIR_BAYT   = SATIR_BAYT_VARSAYILAN,
  parameter int ADRES_BIT    = ADRES_BIT_VARSAYILAN,
  parameter int VERI_BIT     = VERI_BIT_VARSAYILAN
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    l1v_istek_gecerli_i,
  output logic                    l1v_istek_hazir_o,
  input  logic [ADRES_BIT-1:0]    l1v_istek_adres_i,
  input  logic                    l1v_istek_yaz_i,
  input  logic [VERI_BIT-1:0]     l1v_istek_veri_i,
  input  logic [VERI_BIT/8-1:0]   l1v_istek_maske_i,
  output logic [VERI_BIT-1:0]     l1v_veri_o,
  output logic                    l1v_veri_gecerli_o,
  input  logic                    l1v_veri_hazir_i,
  output logic                    bellek_istek_gecerli_o,
  input  logic                    bellek_istek_hazir_i,
  output logic [ADRES_BIT-1:0]    bellek_istek_adres_o,
  output logic                    bellek_istek_yaz_o,
  output logic [VERI_BIT-1:0]     bellek_istek_veri_o,
  output logic [VERI_BIT/8-1:0]   bellek_istek_maske_o,
  input  logic                    bellek_cevap_gecerli_i,
  input  logic [8*SATIR_BAYT-1:0] bellek_cevap_veri_i,
  output logic                    bellek_cevap_hazir_o
);

  localparam int IDX       = $clog2(SATIR_SAYISI);
  localparam int OFS       = $clog2(SATIR_BAYT);
  localparam int ETIKET    = ADRES_BIT - IDX - OFS;
  localparam int MB        = VERI_BIT / 8;
  localparam int SATIR_BIT = 8 * SATIR_BAYT;

  durum_t durum;

  // Byte-in-word bits are never needed, so the request address is kept word-aligned
  logic [ADRES_BIT-1:2] adres_q;
  logic                 yaz_q;
  logic [VERI_BIT-1:0]  veri_q;
  logic [MB-1:0]        maske_q;

  logic [IDX-1:0]       idx;
  logic [ETIKET-1:0]    etiket;
  logic [31:0]          kelime;
  logic                 satir_gecerli;
  logic [ETIKET-1:0]    satir_etiket;
  logic                 isabet;
  logic                 dolum_al;
  logic [VERI_BIT-1:0]  okunan_kelime;
  logic [VERI_BIT-1:0]  dolum_kelime;
  logic                 unused_adres_bitleri;

  logic [SATIR_BIT-1:0] veri_dizi [SATIR_SAYISI];

  assign unused_adres_bitleri = ^l1v_istek_adres_i[1:0];

  assign idx    = adres_q[IDX+OFS-1:OFS];
  assign etiket = adres_q[ADRES_BIT-1:IDX+OFS];

  if (OFS > 2) begin : g_kelime
    assign kelime = 32'(adres_q[OFS-1:2]);
  end else begin : g_tek_kelime
    assign kelime = '0;
  end

  l1v_etiket_dizisi #(
    .SATIR_SAYISI(SATIR_SAYISI),
    .IDX         (IDX),
    .ETIKET      (ETIKET)
  ) u_etiket (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .oku_idx    (idx),
    .oku_gecerli(satir_gecerli),
    .oku_etiket (satir_etiket),
    .yaz_en     (dolum_al),
    .yaz_idx    (idx),
    .yaz_etiket (etiket)
  );

  assign isabet        = satir_gecerli && (satir_etiket == etiket);
  assign dolum_al      = (durum == OKU_BEKLE) && bellek_cevap_gecerli_i && bellek_cevap_hazir_o;
  assign okunan_kelime = veri_dizi[idx][kelime*VERI_BIT +: VERI_BIT];
  assign dolum_kelime  = bellek_cevap_veri_i[kelime*VERI_BIT +: VERI_BIT];

  // Data array: whole-line fill on a miss, byte-masked merge on a store hit
  always_ff @(posedge clk_i) begin
    if (dolum_al) begin
      veri_dizi[idx] <= bellek_cevap_veri_i;
    end else if ((durum == ARA) && yaz_q && isabet) begin
      for (int b = 0; b < MB; b++) begin
        if (maske_q[b]) begin
          veri_dizi[idx][kelime*VERI_BIT + b*8 +: 8] <= veri_q[b*8 +: 8];
        end
      end
    end
  end

  // Request sequencing, next-level handshakes and registered interface outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum                  <= BOSTA;
      l1v_istek_hazir_o      <= HIGH;
      bellek_cevap_hazir_o   <= HIGH;
      l1v_veri_gecerli_o     <= LOW;
      l1v_veri_o             <= '0;
      bellek_istek_gecerli_o <= LOW;
      bellek_istek_adres_o   <= '0;
      bellek_istek_yaz_o     <= LOW;
      bellek_istek_veri_o    <= '0;
      bellek_istek_maske_o   <= '0;
      adres_q                <= '0;
      yaz_q                  <= LOW;
      veri_q                 <= '0;
      maske_q                <= '0;
    end else begin
      case (durum)
        BOSTA: begin
          if (l1v_istek_gecerli_i && l1v_istek_hazir_o) begin
            adres_q              <= l1v_istek_adres_i[ADRES_BIT-1:2];
            yaz_q                <= l1v_istek_yaz_i;
            veri_q               <= l1v_istek_veri_i;
            maske_q              <= l1v_istek_maske_i;
            l1v_istek_hazir_o    <= LOW;
            bellek_cevap_hazir_o <= LOW;
            durum                <= ARA;
          end
        end
        ARA: begin
          if (!yaz_q && isabet) begin
            l1v_veri_o         <= okunan_kelime;
            l1v_veri_gecerli_o <= HIGH;
            durum              <= CEVAP;
          end else if (!yaz_q) begin
            bellek_istek_gecerli_o <= HIGH;
            bellek_istek_adres_o   <= {adres_q[ADRES_BIT-1:OFS], {OFS{1'b0}}};
            bellek_istek_yaz_o     <= LOW;
            bellek_istek_veri_o    <= '0;
            bellek_istek_maske_o   <= '0;
            durum                  <= OKU_ISTE;
          end else begin
            // store goes downstream whether or not it hit; a miss never allocates
            bellek_istek_gecerli_o <= HIGH;
            bellek_istek_adres_o   <= {adres_q, 2'b00};
            bellek_istek_yaz_o     <= HIGH;
            bellek_istek_veri_o    <= veri_q;
            bellek_istek_maske_o   <= maske_q;
            durum                  <= YAZ_ISTE;
          end
        end
        CEVAP: begin
          if (l1v_veri_hazir_i) begin
            l1v_veri_gecerli_o   <= LOW;
            l1v_istek_hazir_o    <= HIGH;
            bellek_cevap_hazir_o <= HIGH;
            durum                <= BOSTA;
          end
        end
        OKU_ISTE: begin
          if (bellek_istek_hazir_i) begin
            bellek_istek_gecerli_o <= LOW;
            bellek_cevap_hazir_o   <= HIGH;
            durum                  <= OKU_BEKLE;
          end
        end
        OKU_BEKLE: begin
          if (bellek_cevap_gecerli_i) begin
            bellek_cevap_hazir_o <= LOW;
            l1v_veri_o           <= dolum_kelime;
            l1v_veri_gecerli_o   <= HIGH;
            durum                <= CEVAP;
          end
        end
        YAZ_ISTE: begin
          if (bellek_istek_hazir_i) begin
            bellek_istek_gecerli_o <= LOW;
            l1v_istek_hazir_o      <= HIGH;
            bellek_cevap_hazir_o   <= HIGH;
            durum                  <= BOSTA;
          end
        end
        default: begin
          durum <= BOSTA;
        end
      endcase
    end
  end

endmodule
